// File: rtl/cfg_chain_pkg.sv
// Shared definitions for the serial configuration-chain controller.
package cfg_chain_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned DEFAULT_DIV   = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LOAD     = 2'd3
  } state_t;

endpackage

// File: rtl/cfg_chain_tick.sv
// Half-period divider: counts 0..DIV-1, flags the final count, restarts on clear.
module cfg_chain_tick
  import cfg_chain_pkg::*;
#(
  parameter int unsigned DIV = DEFAULT_DIV
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_clr,
  output logic o_last_c
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign o_last_c = (r_cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_clr || o_last_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cfg_chain_ctrl.sv
// Shifts a parallel word MSB-first into an external flop chain, strobes its
// shadow latches and captures the chain's previous contents from the tail.
module cfg_chain_ctrl
  import cfg_chain_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned DIV   = DEFAULT_DIV
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             abort,
  output logic             ser_data,
  output logic             ser_clk,
  output logic             ser_load,
  input  logic             ser_rdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned BIT_W = $clog2(WIDTH);

  state_t           r_state,    w_state_nxt;
  logic [WIDTH-2:0] r_sreg,     w_sreg_nxt;
  logic [WIDTH-1:0] r_cap,      w_cap_nxt;
  logic [WIDTH-1:0] r_rdata,    w_rdata_nxt;
  logic [BIT_W-1:0] r_bitcnt,   w_bitcnt_nxt;
  logic             r_ser_data, w_ser_data_nxt;
  logic             r_ser_clk,  w_ser_clk_nxt;
  logic             r_ser_load, w_ser_load_nxt;
  logic             r_done,     w_done_nxt;
  logic             r_in_ready;
  logic             r_busy;
  logic             w_last;
  logic             w_div_clr;

  // Divider restarts on every state change and is held clear while idle.
  assign w_div_clr = (w_state_nxt != r_state) || (r_state == IDLE);

  cfg_chain_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk      (clk),
    .resetn   (resetn),
    .i_clr    (w_div_clr),
    .o_last_c (w_last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_sreg     <= '0;
      r_cap      <= '0;
      r_rdata    <= '0;
      r_bitcnt   <= '0;
      r_ser_data <= 1'b0;
      r_ser_clk  <= 1'b0;
      r_ser_load <= 1'b0;
      r_done     <= 1'b0;
      r_in_ready <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_sreg     <= w_sreg_nxt;
      r_cap      <= w_cap_nxt;
      r_rdata    <= w_rdata_nxt;
      r_bitcnt   <= w_bitcnt_nxt;
      r_ser_data <= w_ser_data_nxt;
      r_ser_clk  <= w_ser_clk_nxt;
      r_ser_load <= w_ser_load_nxt;
      r_done     <= w_done_nxt;
      r_in_ready <= (w_state_nxt == IDLE);
      r_busy     <= (w_state_nxt != IDLE);
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_sreg_nxt     = r_sreg;
    w_cap_nxt      = r_cap;
    w_rdata_nxt    = r_rdata;
    w_bitcnt_nxt   = r_bitcnt;
    w_ser_data_nxt = r_ser_data;
    w_ser_clk_nxt  = r_ser_clk;
    w_ser_load_nxt = r_ser_load;
    w_done_nxt     = 1'b0;

    case (r_state)
      IDLE: begin
        if (in_valid) begin
          w_state_nxt    = SHIFT_LO;
          w_sreg_nxt     = in_data[WIDTH-2:0];
          w_ser_data_nxt = in_data[WIDTH-1];
          w_bitcnt_nxt   = BIT_W'(WIDTH - 1);
        end
      end
      SHIFT_LO: begin
        // Tail is sampled on the edge that raises ser_clk, before the chain shifts.
        if (w_last) begin
          w_state_nxt   = SHIFT_HI;
          w_ser_clk_nxt = 1'b1;
          w_cap_nxt     = {r_cap[WIDTH-2:0], ser_rdata};
        end
      end
      SHIFT_HI: begin
        if (w_last) begin
          w_ser_clk_nxt = 1'b0;
          if (r_bitcnt != '0) begin
            w_state_nxt    = SHIFT_LO;
            w_bitcnt_nxt   = r_bitcnt - BIT_W'(1);
            w_sreg_nxt     = r_sreg << 1;
            w_ser_data_nxt = r_sreg[WIDTH-2];
          end else begin
            w_state_nxt    = LOAD;
            w_ser_load_nxt = 1'b1;
          end
        end
      end
      LOAD: begin
        if (w_last) begin
          w_state_nxt    = IDLE;
          w_ser_load_nxt = 1'b0;
          w_ser_data_nxt = 1'b0;
          w_rdata_nxt    = r_cap;
          w_done_nxt     = 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    if (abort && (r_state != IDLE)) begin
      w_state_nxt    = IDLE;
      w_ser_clk_nxt  = 1'b0;
      w_ser_load_nxt = 1'b0;
      w_ser_data_nxt = 1'b0;
      w_bitcnt_nxt   = '0;
      w_rdata_nxt    = r_rdata;
      w_done_nxt     = 1'b0;
    end
  end

  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign ser_data = r_ser_data;
  assign ser_clk  = r_ser_clk;
  assign ser_load = r_ser_load;
  assign rdata    = r_rdata;

endmodule

// File: tb/tb_cfg_chain_ctrl.sv
// Bench for cfg_chain_ctrl: three configurations, a behavioural chain model and
// a word-level reference (chain ends holding the sent word, rdata returns the old one).
module tb_cfg_chain_ctrl;

  logic clk    = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // 8-bit, DIV=2 instance with a modelled chain on its serial port
  logic       in_valid8, in_ready8, abort8, ser_data8, ser_clk8, ser_load8, ser_rdata8, busy8, done8;
  logic [7:0] in_data8, rdata8;
  logic [7:0] chain8  = 8'h00;
  logic [7:0] shadow8 = 8'h00;
  logic       preload8;
  logic [7:0] exp_chain, exp_rdata;

  // 4-bit, DIV=1 instance
  logic       in_valid4, in_ready4, abort4, ser_data4, ser_clk4, ser_load4, ser_rdata4, busy4, done4;
  logic [3:0] in_data4, rdata4;
  logic [3:0] chain4 = 4'h0;

  // 32-bit, DIV=3 instance with the tail tied low
  logic        in_valid32, in_ready32, abort32, ser_data32, ser_clk32, ser_load32, busy32, done32;
  logic        ser_rdata32;
  logic [31:0] in_data32, rdata32;

  always @(posedge ser_clk8 or posedge preload8) begin
    if (preload8) chain8 <= 8'h3C;
    else          chain8 <= {chain8[6:0], ser_data8};
  end
  assign ser_rdata8 = chain8[7];

  always @(posedge clk) begin
    if (ser_load8) shadow8 <= chain8;
  end

  always @(posedge ser_clk4) chain4 <= {chain4[2:0], ser_data4};
  assign ser_rdata4  = chain4[3];
  assign ser_rdata32 = 1'b0;

  cfg_chain_ctrl #(.WIDTH(8), .DIV(2)) u_dut8 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid8), .in_data(in_data8), .in_ready(in_ready8),
    .abort(abort8), .ser_data(ser_data8), .ser_clk(ser_clk8), .ser_load(ser_load8),
    .ser_rdata(ser_rdata8), .busy(busy8), .done(done8), .rdata(rdata8)
  );

  cfg_chain_ctrl #(.WIDTH(4), .DIV(1)) u_dut4 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid4), .in_data(in_data4), .in_ready(in_ready4),
    .abort(abort4), .ser_data(ser_data4), .ser_clk(ser_clk4), .ser_load(ser_load4),
    .ser_rdata(ser_rdata4), .busy(busy4), .done(done4), .rdata(rdata4)
  );

  cfg_chain_ctrl #(.WIDTH(32), .DIV(3)) u_dut32 (
    .clk(clk), .resetn(resetn), .in_valid(in_valid32), .in_data(in_data32), .in_ready(in_ready32),
    .abort(abort32), .ser_data(ser_data32), .ser_clk(ser_clk32), .ser_load(ser_load32),
    .ser_rdata(ser_rdata32), .busy(busy32), .done(done32), .rdata(rdata32)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // One full 8-bit transfer, checking waveform timing and the word-level result.
  task automatic xfer8(input logic [7:0] w, input bit poke_busy);
    int k, rises, last_rise, load_cyc;
    bit ready_low;
    logic sc_p1, sc_p2, sd_p1, sd_p2;
    logic [7:0] exp_rd;
    exp_rd = exp_chain;
    @(negedge clk);
    check_eq("ready_before", 64'(in_ready8), 64'd1);
    in_valid8 = 1'b1;
    in_data8  = w;
    @(negedge clk);
    in_valid8 = 1'b0;
    in_data8  = 8'($urandom);
    k = 0; rises = 0; last_rise = 0; load_cyc = 0; ready_low = 1'b1;
    sc_p1 = ser_clk8; sc_p2 = ser_clk8; sd_p1 = ser_data8; sd_p2 = ser_data8;
    while (!done8 && k < 200) begin
      if (!sc_p1 && ser_clk8) begin
        if (rises > 0) check_eq("clk_period", 64'(k - last_rise), 64'd4);
        check_eq("data_setup", 64'({sc_p2, sc_p1, sd_p2, sd_p1}), 64'({2'b00, ser_data8, ser_data8}));
        if (rises < 8) check_eq("ser_bit", 64'(ser_data8), 64'(w[7 - rises]));
        rises++;
        last_rise = k;
      end
      if (ser_load8) load_cyc++;
      if (in_ready8) ready_low = 1'b0;
      if (poke_busy && k == 5) begin
        in_valid8 = 1'b1;
        in_data8  = 8'hFF;
      end else begin
        in_valid8 = 1'b0;
      end
      sc_p2 = sc_p1; sd_p2 = sd_p1; sc_p1 = ser_clk8; sd_p1 = ser_data8;
      @(negedge clk);
      k++;
    end
    in_valid8 = 1'b0;
    check_eq("latency8", 64'(k), 64'd34);
    check_eq("rises8", 64'(rises), 64'd8);
    check_eq("load_len8", 64'(load_cyc), 64'd2);
    check_eq("ready_low", 64'(ready_low), 64'd1);
    check_eq("chain8", 64'(chain8), 64'(w));
    check_eq("shadow8", 64'(shadow8), 64'(w));
    check_eq("rdata8", 64'(rdata8), 64'(exp_rd));
    exp_rdata = exp_rd;
    exp_chain = w;
    @(negedge clk);
    check_eq("done_pulse", 64'(done8), 64'd0);
  endtask

  task automatic abort8_test(input logic [7:0] w);
    int k, rises;
    logic sc_p;
    bit quiet;
    @(negedge clk);
    in_valid8 = 1'b1;
    in_data8  = w;
    @(negedge clk);
    in_valid8 = 1'b0;
    k = 0; rises = 0; sc_p = ser_clk8;
    while (rises < 3 && k < 100) begin
      @(negedge clk);
      k++;
      if (!sc_p && ser_clk8) rises++;
      sc_p = ser_clk8;
    end
    check_eq("abort_reach", 64'(rises), 64'd3);
    abort8 = 1'b1;
    @(negedge clk);
    abort8 = 1'b0;
    check_eq("abort_busy", 64'(busy8), 64'd0);
    check_eq("abort_ready", 64'(in_ready8), 64'd1);
    check_eq("abort_clk", 64'(ser_clk8), 64'd0);
    check_eq("abort_load", 64'(ser_load8), 64'd0);
    check_eq("abort_data", 64'(ser_data8), 64'd0);
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done8 || ser_load8 || ser_clk8) quiet = 1'b0;
    end
    check_eq("abort_quiet", 64'(quiet), 64'd1);
    check_eq("abort_rdata", 64'(rdata8), 64'(exp_rdata));
    exp_chain = 8'((exp_chain << 3) | (w >> 5));
  endtask

  task automatic reset_in_load8(input logic [7:0] w);
    int k;
    @(negedge clk);
    in_valid8 = 1'b1;
    in_data8  = w;
    @(negedge clk);
    in_valid8 = 1'b0;
    k = 0;
    while (!ser_load8 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check_eq("load_reach", 64'(ser_load8), 64'd1);
    #1 resetn = 1'b0;
    #1;
    check_eq("rst_load", 64'(ser_load8), 64'd0);
    check_eq("rst_clk", 64'(ser_clk8), 64'd0);
    check_eq("rst_busy", 64'(busy8), 64'd0);
    check_eq("rst_rdata", 64'(rdata8), 64'd0);
    check_eq("rst_ready", 64'(in_ready8), 64'd1);
    @(negedge clk);
    resetn = 1'b1;
    exp_chain = w;
    exp_rdata = 8'h00;
  endtask

  task automatic back2back4();
    int cyc, na, nd;
    int a[2];
    int d[2];
    logic [3:0] rd_first;
    cyc = 0; na = 0; nd = 0; rd_first = 4'h0;
    a[0] = 0; a[1] = 0; d[0] = 0; d[1] = 0;
    @(negedge clk);
    in_valid4 = 1'b1;
    in_data4  = 4'hF;
    while (nd < 2 && cyc < 60) begin
      if (done4) begin
        d[nd] = cyc;
        if (nd == 0) rd_first = rdata4;
        nd++;
      end
      if (in_ready4 && in_valid4 && na < 2) begin
        a[na] = cyc;
        na++;
      end
      @(negedge clk);
      cyc++;
      if (na == 1) in_data4 = 4'h0;
      if (na == 2) in_valid4 = 1'b0;
    end
    in_valid4 = 1'b0;
    check_eq("b2b_accepts", 64'(na), 64'd2);
    check_eq("b2b_dones", 64'(nd), 64'd2);
    check_eq("b2b_accept_in_done", 64'(a[1]), 64'(d[0]));
    check_eq("b2b_lat1", 64'(d[0] - a[0] - 1), 64'd9);
    check_eq("b2b_lat2", 64'(d[1] - a[1] - 1), 64'd9);
    check_eq("b2b_rdata1", 64'(rd_first), 64'h0);
    check_eq("b2b_rdata2", 64'(rdata4), 64'hF);
    check_eq("b2b_chain", 64'(chain4), 64'h0);
  endtask

  task automatic wide32();
    int k, nb;
    logic sc_p;
    logic [31:0] bits;
    @(negedge clk);
    in_valid32 = 1'b1;
    in_data32  = 32'h8000_0001;
    @(negedge clk);
    in_valid32 = 1'b0;
    in_data32  = $urandom;
    k = 0; nb = 0; bits = '0; sc_p = ser_clk32;
    while (!done32 && k < 400) begin
      if (!sc_p && ser_clk32) begin
        bits = {bits[30:0], ser_data32};
        nb++;
      end
      sc_p = ser_clk32;
      @(negedge clk);
      k++;
    end
    check_eq("lat32", 64'(k), 64'd195);
    check_eq("rises32", 64'(nb), 64'd32);
    check_eq("bits32", 64'(bits), 64'h8000_0001);
    check_eq("rdata32", 64'(rdata32), 64'h0);
  endtask

  initial begin
    in_valid8 = 1'b0; in_data8 = '0; abort8 = 1'b0; preload8 = 1'b0;
    in_valid4 = 1'b0; in_data4 = '0; abort4 = 1'b0;
    in_valid32 = 1'b0; in_data32 = '0; abort32 = 1'b0;
    #1 resetn = 1'b0;
    #2;
    check_eq("reset_ready", 64'(in_ready8), 64'd1);
    check_eq("reset_busy", 64'(busy8), 64'd0);
    check_eq("reset_done", 64'(done8), 64'd0);
    check_eq("reset_clk", 64'(ser_clk8), 64'd0);
    check_eq("reset_data", 64'(ser_data8), 64'd0);
    check_eq("reset_load", 64'(ser_load8), 64'd0);
    check_eq("reset_rdata", 64'(rdata8), 64'd0);
    preload8 = 1'b1;
    #1 preload8 = 1'b0;
    exp_chain = 8'h3C;
    exp_rdata = 8'h00;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;

    back2back4();
    wide32();
    xfer8(8'hA5, 1'b0);
    xfer8(8'h12, 1'b1);
    repeat (6) xfer8(8'($urandom), 1'b0);
    abort8_test(8'($urandom));
    xfer8(8'($urandom), 1'b0);
    reset_in_load8(8'($urandom));
    xfer8(8'h81, 1'b0);
    repeat (2) xfer8(8'($urandom), 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cfg_chain_ctrl.md
Name: cfg_chain_ctrl

Overview:
Serial configuration-chain controller. It takes a parallel configuration word over a valid/ready handshake. It shifts the word MSB-first into an external chain of DFRX2-style flops, using a generated shift clock, then pulses a load strobe so the chain's shadow latches update. It simultaneously captures the chain's serial return data, so the previous contents are read back. It sits between the housekeeping/SPI register block and the pad/analog configuration chains.

Parameters:
WIDTH, 32, chain length in bits and width of the parallel word (legal: 2..64)
DIV, 2, system clocks per half period of ser_clk and length of the load pulse (legal: 1..255)

Ports:
clk  input  1  system clock; all state changes on the rising edge
resetn  input  1  asynchronous active-low reset
in_valid  input  1  parallel word offered
in_data  input  WIDTH  word to shift; bit WIDTH-1 is shifted first
in_ready  output  1  controller idle and able to accept a word
abort  input  1  synchronous cancel of the transfer in progress
ser_data  output  1  serial data to the chain head
ser_clk  output  1  chain shift clock; the chain samples on its rising edge
ser_load  output  1  chain load/update strobe, active high
ser_rdata  input  1  serial data returned from the chain tail
busy  output  1  transfer in progress (high whenever in_ready is low)
done  output  1  one-cycle pulse when a transfer completes normally
rdata  output  WIDTH  word captured from ser_rdata; first captured bit lands in bit WIDTH-1

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; in_ready=1; busy=0; done=0; ser_clk=0; ser_data=0; ser_load=0; rdata=0; all counters 0.
- States: IDLE, SHIFT_LO, SHIFT_HI, LOAD.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data into the shift register, set bit counter to WIDTH-1 and divider to 0, and go to SHIFT_LO.
  - ser_data takes in_data[WIDTH-1] on the same edge.
- SHIFT_LO:
  - ser_clk=0 and ser_data is stable for DIV cycles.
  - At divider=DIV-1, go to SHIFT_HI.
- SHIFT_HI:
  - ser_clk=1 for DIV cycles.
  - On the entry edge, sample ser_rdata into the capture register LSB, shifting left.
  - At divider=DIV-1:
    - If the bit counter is nonzero: decrement it, shift the data register, drive the next bit on ser_data, and go to SHIFT_LO.
    - Otherwise go to LOAD.
- LOAD:
  - ser_clk=0 and ser_load=1 for DIV cycles.
  - Then go to IDLE, copy the capture register into rdata, and pulse done=1 for exactly one cycle (the first IDLE cycle).
- Latency: accept edge to done edge is 2*DIV*WIDTH + DIV cycles. The next word can be accepted in the same cycle done is high.
- Divider: counts 0..DIV-1 and clears on every state change. DIV=1 gives ser_clk = clk/2 and a 1-cycle load pulse.
- abort: takes effect in any non-IDLE state.
  - Next edge: IDLE, ser_clk=0, ser_load=0, ser_data=0.
  - No done pulse; rdata is unchanged.
  - abort is ignored in IDLE, and an abort in that cycle does not block an acceptance.
- in_data is not sampled after acceptance. in_valid while busy is ignored (in_ready=0).
- ser_clk, ser_data and ser_load are register outputs with no combinational paths from inputs.
- Reset mid-transfer: outputs clear immediately and asynchronously. The chain contents are undefined, but ser_load is never asserted.

Decomposition:
- Shared package cfg_chain_pkg holds the state encoding constants (IDLE=2'd0, SHIFT_LO=2'd1, SHIFT_HI=2'd2, LOAD=2'd3) and the default WIDTH and DIV.
- One sub-module, cfg_chain_tick:
  - Parameterised DIV half-period counter with a clear input.
  - Emits a one-cycle "last" tick when divider=DIV-1.
  - Reused by the LOAD timing.

Test Plan:
- WIDTH=8, DIV=2, send 0xA5 with ser_rdata tied through an 8-flop model chain preloaded with 0x3C:
  - ser_clk shows 8 rising edges, each 4 clocks apart, and ser_data is stable for 2 clocks before each rise.
  - ser_load is high for 2 clocks.
  - done fires 34 cycles after acceptance.
  - The chain holds 0xA5 and rdata=0x3C.
- DIV=1, WIDTH=4, send 0xF then 0x0 back-to-back with in_valid held high:
  - The second word is accepted in the done cycle.
  - Each transfer takes 9 cycles.
  - rdata after the second transfer is 0xF.
- Assert abort during the 3rd SHIFT_HI of an 8-bit transfer:
  - IDLE on the next edge, ser_clk=0, no ser_load, no done.
  - rdata keeps its previous value.
- Drop resetn mid-LOAD:
  - ser_load, ser_clk, busy and rdata go to 0 without a clock edge.
  - After release, in_ready=1 and a new 0x81 transfer completes normally.
- in_valid pulsed while busy with in_data=0xFF:
  - Ignored; the transfer in progress finishes with its original word.
  - in_ready stays 0 until done.
- WIDTH=32, DIV=3, word 0x8000_0001:
  - The first and last ser_data bits are 1 and the other 30 are 0.
  - done fires 195 cycles after acceptance.
